// File: rtl/pipeline_ctrl_pkg.sv
// Shared CPU control package: register-address width and the memory-wait FSM encoding.
package pipeline_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WCNT_W     = 8;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_MWAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID source register that a load in EX is about to write.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic                  id_rs1_re_i,
  input  logic                  id_rs2_re_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
  input  logic                  ex_reg_we_i,
  input  logic                  ex_is_load_i,
  output logic                  load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 is hardwired, so a load targeting it never creates a dependency.
  assign rs1_hit    = id_rs1_re_i && (id_rs1_addr_i == ex_rd_addr_i);
  assign rs2_hit    = id_rs2_re_i && (id_rs2_addr_i == ex_rd_addr_i);
  assign load_use_o = ex_is_load_i && ex_reg_we_i && (ex_rd_addr_i != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: memory-wait stalls with timeout, branch flush, load-use stall.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_RUN   | no outstanding data access beyond the current cycle
// ST_MWAIT | waiting for dmem_ack_i; wcnt counts cycles of the access
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 8,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic                  id_rs1_re_i,
  input  logic                  id_rs2_re_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
  input  logic                  ex_reg_we_i,
  input  logic                  ex_is_load_i,
  input  logic                  ex_branch_taken_i,
  input  logic                  mem_access_i,
  input  logic                  dmem_ack_i,
  output logic                  dmem_req_o,
  output logic                  pc_stall_o,
  output logic                  if_id_stall_o,
  output logic                  id_ex_stall_o,
  output logic                  ex_mem_stall_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_flush_o,
  output logic                  mem_wb_flush_o,
  output logic                  dmem_err_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  localparam logic [WCNT_W-1:0] TIMEOUT_C = WCNT_W'(MEM_TIMEOUT);

  mem_state_e        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              err_q, err_d;
  logic              br_pend_q, br_pend_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic timeout;
  logic mem_stall;
  logic load_use;
  logic branch;

  hazard_detect u_hazard_detect (
    .id_rs1_addr_i (id_rs1_addr_i),
    .id_rs2_addr_i (id_rs2_addr_i),
    .id_rs1_re_i   (id_rs1_re_i),
    .id_rs2_re_i   (id_rs2_re_i),
    .ex_rd_addr_i  (ex_rd_addr_i),
    .ex_reg_we_i   (ex_reg_we_i),
    .ex_is_load_i  (ex_is_load_i),
    .load_use_o    (load_use)
  );

  assign dmem_req_o = mem_access_i;
  assign timeout    = (state_q == ST_MWAIT) && (wcnt_q == TIMEOUT_C);
  assign mem_stall  = mem_access_i && !dmem_ack_i && !timeout;
  // A branch seen while EX was frozen is remembered and applied on release.
  assign branch     = ex_branch_taken_i || br_pend_q;

  // State, wait counter, error pulse, pending branch and stall counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      wcnt_q      <= '0;
      err_q       <= 1'b0;
      br_pend_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      err_q       <= err_d;
      br_pend_q   <= br_pend_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Memory-wait FSM next state; a dropped access request also ends the wait.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    err_d   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_access_i && !dmem_ack_i) begin
          state_d = ST_MWAIT;
          wcnt_d  = WCNT_W'(1);
        end
      end
      ST_MWAIT: begin
        if (!mem_access_i || dmem_ack_i) begin
          state_d = ST_RUN;
          wcnt_d  = '0;
        end else if (timeout) begin
          state_d = ST_RUN;
          wcnt_d  = '0;
          err_d   = 1'b1;
        end else begin
          wcnt_d  = wcnt_q + WCNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        wcnt_d  = '0;
      end
    endcase
  end

  // Stall/flush outputs by priority: memory stall, then branch, then load-use.
  always_comb begin
    pc_stall_o     = 1'b0;
    if_id_stall_o  = 1'b0;
    id_ex_stall_o  = 1'b0;
    ex_mem_stall_o = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    mem_wb_flush_o = 1'b0;
    br_pend_d      = 1'b0;
    if (mem_stall) begin
      pc_stall_o     = 1'b1;
      if_id_stall_o  = 1'b1;
      id_ex_stall_o  = 1'b1;
      ex_mem_stall_o = 1'b1;
      mem_wb_flush_o = 1'b1;
      br_pend_d      = branch;
    end else if (branch) begin
      if_id_flush_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
    end else if (load_use) begin
      pc_stall_o     = 1'b1;
      if_id_stall_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
    end
  end

  // Saturating count of PC-stall cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_stall_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  assign dmem_err_o  = err_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: behavioural model compared every cycle, directed scenarios plus random traffic.
module tb_pipeline_ctrl;

  localparam int T = 8;
  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [4:0]   id_rs1_addr_i = '0, id_rs2_addr_i = '0, ex_rd_addr_i = '0;
  logic         id_rs1_re_i = 0, id_rs2_re_i = 0, ex_reg_we_i = 0, ex_is_load_i = 0;
  logic         ex_branch_taken_i = 0, mem_access_i = 0, dmem_ack_i = 0;
  logic         dmem_req_o, pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o;
  logic         if_id_flush_o, id_ex_flush_o, mem_wb_flush_o, dmem_err_o;
  logic [W-1:0] stall_cnt_o;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_TIMEOUT(T), .CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_re_i(id_rs1_re_i), .id_rs2_re_i(id_rs2_re_i),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_reg_we_i(ex_reg_we_i), .ex_is_load_i(ex_is_load_i),
    .ex_branch_taken_i(ex_branch_taken_i), .mem_access_i(mem_access_i), .dmem_ack_i(dmem_ack_i),
    .dmem_req_o(dmem_req_o), .pc_stall_o(pc_stall_o), .if_id_stall_o(if_id_stall_o),
    .id_ex_stall_o(id_ex_stall_o), .ex_mem_stall_o(ex_mem_stall_o),
    .if_id_flush_o(if_id_flush_o), .id_ex_flush_o(id_ex_flush_o), .mem_wb_flush_o(mem_wb_flush_o),
    .dmem_err_o(dmem_err_o), .stall_cnt_o(stall_cnt_o)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Model state: age of the outstanding access, pending branch, expected registered outputs.
  int m_age = 0;
  bit m_pend = 0;
  bit m_err = 0;
  int m_cnt = 0;
  bit e_ms, e_pc, e_ifs, e_ids, e_exs, e_iff, e_idf, e_mwf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_age = 0; m_pend = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic model_expect();
    bit hit, br;
    hit = ex_is_load_i && ex_reg_we_i && (ex_rd_addr_i != 0) &&
          ((id_rs1_re_i && id_rs1_addr_i == ex_rd_addr_i) || (id_rs2_re_i && id_rs2_addr_i == ex_rd_addr_i));
    e_ms  = mem_access_i && !dmem_ack_i && (m_age != T);
    br    = ex_branch_taken_i || m_pend;
    e_pc  = e_ms || (!br && hit);
    e_ifs = e_pc;
    e_ids = e_ms;
    e_exs = e_ms;
    e_mwf = e_ms;
    e_iff = !e_ms && br;
    e_idf = !e_ms && (br || hit);
  endtask

  task automatic model_advance();
    m_err = mem_access_i && !dmem_ack_i && (m_age == T);
    if (e_pc && m_cnt < (1 << W) - 1) m_cnt++;
    m_pend = e_ms && (m_pend || ex_branch_taken_i);
    m_age = (mem_access_i && !dmem_ack_i && m_age < T) ? m_age + 1 : 0;
  endtask

  task automatic compare_all();
    chk("dmem_req", 32'(dmem_req_o), 32'(mem_access_i));
    chk("pc_stall", 32'(pc_stall_o), 32'(e_pc));
    chk("if_id_stall", 32'(if_id_stall_o), 32'(e_ifs));
    chk("id_ex_stall", 32'(id_ex_stall_o), 32'(e_ids));
    chk("ex_mem_stall", 32'(ex_mem_stall_o), 32'(e_exs));
    chk("if_id_flush", 32'(if_id_flush_o), 32'(e_iff));
    chk("id_ex_flush", 32'(id_ex_flush_o), 32'(e_idf));
    chk("mem_wb_flush", 32'(mem_wb_flush_o), 32'(e_mwf));
    chk("dmem_err", 32'(dmem_err_o), 32'(m_err));
    chk("stall_cnt", 32'(stall_cnt_o), 32'(m_cnt));
  endtask

  // Called at posedge+1 after inputs are applied: checks this cycle's outputs.
  task automatic settle();
    #1;
    model_expect();
    compare_all();
  endtask

  task automatic advance();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1_addr_i = '0; id_rs2_addr_i = '0; ex_rd_addr_i = '0;
    id_rs1_re_i = 0; id_rs2_re_i = 0; ex_reg_we_i = 0; ex_is_load_i = 0;
    ex_branch_taken_i = 0; mem_access_i = 0; dmem_ack_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    bit act;
    int lat;
    idle();
    #2;
    chk("reset_stall_cnt", 32'(stall_cnt_o), 0);
    chk("reset_dmem_err", 32'(dmem_err_o), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    // Load writes x5 while ID reads x5: single-cycle stall.
    ex_is_load_i = 1; ex_reg_we_i = 1; ex_rd_addr_i = 5'd5; id_rs1_addr_i = 5'd5; id_rs1_re_i = 1;
    settle();
    chk("lu_pc_stall", 32'(pc_stall_o), 1);
    chk("lu_if_id_stall", 32'(if_id_stall_o), 1);
    chk("lu_id_ex_flush", 32'(id_ex_flush_o), 1);
    advance();
    idle();
    settle();
    chk("lu_one_cycle", 32'(pc_stall_o), 0);
    chk("lu_stall_cnt", 32'(stall_cnt_o), 1);
    advance();

    // Load to x0 with ID reading x0: no hazard.
    ex_is_load_i = 1; ex_reg_we_i = 1; ex_rd_addr_i = 5'd0; id_rs1_addr_i = 5'd0; id_rs1_re_i = 1;
    settle();
    chk("x0_no_stall", 32'(pc_stall_o), 0);
    chk("x0_no_flush", 32'(id_ex_flush_o), 0);
    advance();
    idle();

    // Taken branch flushes IF/ID and ID/EX in the same cycle.
    ex_branch_taken_i = 1;
    settle();
    chk("br_if_id_flush", 32'(if_id_flush_o), 1);
    chk("br_id_ex_flush", 32'(id_ex_flush_o), 1);
    chk("br_no_pc_stall", 32'(pc_stall_o), 0);
    chk("br_no_ex_mem_stall", 32'(ex_mem_stall_o), 0);
    advance();
    idle();

    // Ack three cycles after the request: three full-stall cycles, release in the ack cycle.
    // A branch seen in the first stalled cycle must be applied on release.
    mem_access_i = 1;
    for (int i = 0; i < 3; i++) begin
      ex_branch_taken_i = (i == 0);
      settle();
      chk("mw_pc_stall", 32'(pc_stall_o), 1);
      chk("mw_ex_mem_stall", 32'(ex_mem_stall_o), 1);
      chk("mw_mem_wb_flush", 32'(mem_wb_flush_o), 1);
      chk("mw_no_if_id_flush", 32'(if_id_flush_o), 0);
      advance();
    end
    ex_branch_taken_i = 0;
    dmem_ack_i = 1;
    settle();
    chk("mw_release", 32'(pc_stall_o), 0);
    chk("mw_release_flush", 32'(mem_wb_flush_o), 0);
    chk("mw_held_branch", 32'(if_id_flush_o), 1);
    advance();
    idle();

    // Never acked: stall for MEM_TIMEOUT cycles, then one error pulse.
    mem_access_i = 1;
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      settle();
      if (!pc_stall_o) break;
      stalls++;
      advance();
    end
    chk("to_stall_cycles", 32'(stalls), T);
    advance();
    idle();
    settle();
    chk("to_err_pulse", 32'(dmem_err_o), 1);
    advance();
    settle();
    chk("to_err_once", 32'(dmem_err_o), 0);
    advance();

    // Reset during MWAIT: no error pulse, counter cleared, wait restarts from RUN.
    mem_access_i = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      advance();
    end
    rst_n = 1'b0;
    #1;
    chk("rst_stall_cnt", 32'(stall_cnt_o), 0);
    chk("rst_no_err", 32'(dmem_err_o), 0);
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #2;
      chk("rst_hold_err", 32'(dmem_err_o), 0);
      chk("rst_hold_cnt", 32'(stall_cnt_o), 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      settle();
      if (!pc_stall_o) break;
      stalls++;
      advance();
    end
    chk("rst_restart_cycles", 32'(stalls), T);
    advance();
    idle();

    // Random traffic: accesses with random ack latency (some time out), branches, hazards.
    act = 0;
    lat = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!act && $urandom_range(0, 3) == 0) begin
        act = 1;
        lat = $urandom_range(0, 11);
      end
      mem_access_i      = act;
      dmem_ack_i        = act && (lat == 0);
      ex_branch_taken_i = ($urandom_range(0, 5) == 0);
      ex_is_load_i      = 1'($urandom_range(0, 1));
      ex_reg_we_i       = ($urandom_range(0, 3) != 0);
      ex_rd_addr_i      = 5'($urandom_range(0, 3));
      id_rs1_addr_i     = 5'($urandom_range(0, 3));
      id_rs2_addr_i     = 5'($urandom_range(0, 3));
      id_rs1_re_i       = 1'($urandom_range(0, 1));
      id_rs2_re_i       = 1'($urandom_range(0, 1));
      settle();
      if (act) begin
        if (!e_ms) act = 0;
        else lat--;
      end
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 8: the maximum number of MWAIT cycles before the access is abandoned; legal range is 2..255.
REQ-002 SHALL have parameter CNT_W, default 16: the width of the stall performance counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports id_rs1_addr_i and id_rs2_addr_i, input, 5 bits each: the source registers of the instruction in ID.
REQ-006 SHALL have ports id_rs1_re_i and id_rs2_re_i, input, 1 bit each: the ID instruction reads rs1 / rs2.
REQ-007 SHALL have ports ex_rd_addr_i (input, 5 bits), ex_reg_we_i (input, 1 bit) and ex_is_load_i (input, 1 bit): the destination register, write enable and load flag of the instruction in EX.
REQ-008 SHALL have port ex_branch_taken_i, input, 1 bit: a taken branch or jump is resolved in EX.
REQ-009 SHALL have port mem_access_i, input, 1 bit: the instruction in MEM performs a load or store.
REQ-010 SHALL have port dmem_ack_i, input, 1 bit: data memory completes the request.
REQ-011 SHALL have port dmem_req_o, output, 1 bit: the request to data memory.
REQ-012 SHALL have ports pc_stall_o, if_id_stall_o, id_ex_stall_o and ex_mem_stall_o, output, 1 bit each: hold the corresponding stage register.
REQ-013 SHALL have ports if_id_flush_o, id_ex_flush_o and mem_wb_flush_o, output, 1 bit each: load a bubble into the corresponding stage register.
REQ-014 SHALL have port dmem_err_o, output, 1 bit: a one-cycle pulse on access timeout.
REQ-015 SHALL have port stall_cnt_o, output, CNT_W bits: the count of cycles in which pc_stall_o was 1.

Function
REQ-016 SHALL implement an FSM with states RUN and MWAIT and an 8-bit wait counter wcnt.
REQ-017 SHALL drive dmem_req_o = mem_access_i in both states, combinationally.
REQ-018 SHALL, in RUN, treat mem_access_i=1 with dmem_ack_i=1 as a zero-wait access (no stall), and with dmem_ack_i=0 go to MWAIT with wcnt=1.
REQ-019 SHALL define mem_stall = mem_access_i & ~dmem_ack_i & ~(state==MWAIT & wcnt==MEM_TIMEOUT), combinationally.
REQ-020 SHALL, in MWAIT, return to RUN on dmem_ack_i=1; otherwise increment wcnt.
REQ-021 SHALL, in MWAIT, when wcnt==MEM_TIMEOUT without ack, pulse dmem_err_o, drop mem_stall and return to RUN.
REQ-022 SHALL, while mem_stall=1, assert all four stall outputs and mem_wb_flush_o, and deassert every other flush.
REQ-023 SHALL define load_use = ex_is_load_i & ex_reg_we_i & (ex_rd_addr_i!=0) & ((id_rs1_re_i & rs1 match) | (id_rs2_re_i & rs2 match)).
REQ-024 SHALL, on load_use with no mem_stall, assert pc_stall_o, if_id_stall_o and id_ex_flush_o.
REQ-025 SHALL, on ex_branch_taken_i with no mem_stall, assert if_id_flush_o and id_ex_flush_o.
REQ-026 SHALL apply priority mem_stall > branch > load_use; a branch concurrent with load_use suppresses the load_use stall.
REQ-027 SHALL hold a branch that arrives during mem_stall (EX is frozen) and apply it in the first cycle after release.
REQ-028 SHALL increment stall_cnt_o each cycle pc_stall_o=1, saturating at all-ones.
REQ-029 SHALL make all outputs except dmem_err_o and stall_cnt_o combinational; dmem_err_o SHALL be registered.

Reset
REQ-030 SHALL, on rst_n=0, immediately force state=RUN, wcnt=0, dmem_err_o=0 and stall_cnt_o=0; combinational outputs then follow their inputs.
REQ-031 SHALL treat reset asserted mid-MWAIT as abandoning the access without an error pulse.

Structure
REQ-032 SHALL place the FSM state encoding and the register-address width (5) in the shared CPU package.
REQ-033 SHALL implement the combinational load-use comparator as a single sub-module named hazard_detect.

Verification
REQ-034 SHALL verify: load writes x5 in EX while ID reads rs1=x5 -> pc_stall_o=1, if_id_stall_o=1, id_ex_flush_o=1 for exactly 1 cycle, and stall_cnt_o=1.
REQ-035 SHALL verify: load to x0 with ID rs1=x0 -> no stall.
REQ-036 SHALL verify: ex_branch_taken_i=1 -> if_id_flush_o=1 and id_ex_flush_o=1 in the same cycle, with no stalls.
REQ-037 SHALL verify: mem_access_i=1 with ack 3 cycles later -> 3 cycles of all stalls plus mem_wb_flush_o, then release in the ack cycle.
REQ-038 SHALL verify: mem_access_i=1 and never ack with MEM_TIMEOUT=8 -> stall releases at wcnt=8 and dmem_err_o pulses once.
REQ-039 SHALL verify: rst_n=0 asserted in MWAIT -> state=RUN, stall_cnt_o=0, and no dmem_err_o pulse.
